ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. Consumes the operand values, destination register and funct3 that ID/EX presents. Computes one result bit per cycle. Holds the pipeline through `busy`, which drives the ID/EX `stall` input, until the result is ready.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  rising-edge clock; sole clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `clr`  in  1  pipeline flush; aborts any operation in progress.
- `start`  in  1  EX-stage instruction is a valid M-extension op (decoded from ID/EX `datapath_out`, gated by `~bubble`).
- `op`  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_val`  in  32  operand A, dividend.
- `rs2_val`  in  32  operand B, divisor.
- `rd`  in  5  destination register.
- `busy`  out  1  stall request to ID/EX and upstream stages; combinational.
- `done`  out  1  one-cycle pulse; `result` and `rd_out` valid.
- `result`  out  32  registered result.
- `rd_out`  out  5  registered destination for writeback.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE with `start` and no `clr`:
  - Latch `op`, `rd` and operand magnitudes.
  - Record result sign:
    - MUL/MULH: sign(A) xor sign(B).
    - MULHSU: sign(A) only.
    - DIV: sign(A) xor sign(B).
    - REM: sign(A).
    - Unsigned ops: positive.
  - Clear the 6-bit iteration counter, then go to CALC.
- Fast path from IDLE straight to DONE, no CALC:
  - Divisor 0: quotient 0xFFFFFFFF, remainder = A.
  - Signed DIV/REM with A = 0x80000000 and B = 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- CALC runs exactly 32 iterations.
  - Multiply: shift-add into a 64-bit product (33-bit add into the upper half, then shift right 1).
  - Divide: restoring; shift remainder:quotient left 1, trial-subtract the divisor, set quotient bit when the result is non-negative.
  - On counter == 31: negate if the recorded sign requires it, select the low or high word by `op`, load `result`/`rd_out`, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `start` is ignored in DONE because the same instruction is still in ID/EX.
- `busy` = ~`clr` & ((IDLE & `start`) | CALC). It is 0 in DONE so the pipeline advances at the end of DONE.
- `clr`: FSM returns to IDLE next edge; no `done` pulse; `result`/`rd_out` unchanged.
- `rst`: FSM IDLE; `busy`, `done`, `result`, `rd_out` and all internal registers cleared to 0. Reset mid-CALC discards the operation.
- Priority: `rst` > `clr` > `start`.
- `result`/`rd_out` hold their last value between `done` pulses.

## Timing
- Normal op, `start` seen at edge 0 (IDLE):
  - CALC spans cycles 1–32.
  - DONE in cycle 33.
  - `busy` high in cycles 0–32 (33 stall cycles).
- Fast path: `busy` high in cycle 0 only; DONE in cycle 1.
- Back-to-back M ops: the second `start` is seen in the cycle after DONE, which is IDLE. No idle gap beyond that one cycle.
- `clr` in the same cycle as `start` in IDLE: `busy`=0, no operation starts.
- `result` is registered; it is valid from the edge that enters DONE until overwritten.

## Configuration
- `MULDIV_DIV_EN` defined:
  - Full RV32M; divider datapath and the divide fast-path checks are built.
- `MULDIV_DIV_EN` undefined:
  - Divider logic is removed.
  - Ops with `op`[2]=1 take the fast path (IDLE→DONE) with `result` = 0.
  - MUL/MULH/MULHSU/MULHU behave identically to the enabled build.

## Test plan
- MUL: A=7, B=6, `rd`=5, `start` held → `busy` for 33 cycles; `done` in cycle 33 with `result`=42, `rd_out`=5.
- MULH: A=0x80000000, B=0x80000000 → `result`=0x40000000. MULHSU: A=0xFFFFFFFF, B=0xFFFFFFFF → `result`=0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (−7), B=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU A=100, B=7 → 14.
- Fast path: DIVU A=5, B=0 → `result`=0xFFFFFFFF, `done` in cycle 1. REM A=0x80000000, B=0xFFFFFFFF → `result`=0, `done` in cycle 1.
- `clr` asserted in CALC cycle 10 → IDLE next cycle, no `done`, `result` retains its previous value. `rst` mid-CALC → all outputs 0.
- Build without `MULDIV_DIV_EN`: DIV A=10, B=2 → `done` in cycle 1 with `result`=0. MUL A=3, B=3 → `result`=9 in cycle 33.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage, one result bit per cycle.
// Build option: define MULDIV_DIV_EN to include the divider; otherwise divide ops complete with result 0.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state_p0, state_nxt;
  logic [2:0]  op_p0;
  logic [4:0]  rd_p0;
  logic        sign_p0;
  logic [31:0] hi_p0, lo_p0, mcand_p0;
  logic [5:0]  cnt_p0;

  logic        a_neg, b_neg, sign_start;
  logic [31:0] a_mag, b_mag;
  logic        fast;
  logic [31:0] fast_res;
  logic [32:0] sum33;
  logic [31:0] hi_nxt, lo_nxt, final_res;
  logic [63:0] prod;
  logic        last;
`ifdef MULDIV_DIV_EN
  logic [32:0] shifted;
  logic [31:0] sub;
  logic        ge;
`endif

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  // Operand decode at issue: signedness, magnitudes, result sign
  always_comb begin
    a_neg      = 1'b0;
    b_neg      = 1'b0;
    sign_start = 1'b0;
    case (op)
      3'b000, 3'b001, 3'b100: begin
        a_neg      = rs1_val[31];
        b_neg      = rs2_val[31];
        sign_start = rs1_val[31] ^ rs2_val[31];
      end
      3'b010, 3'b110: begin
        a_neg      = rs1_val[31];
        b_neg      = (op == 3'b110) ? rs2_val[31] : 1'b0;
        sign_start = rs1_val[31];
      end
      default: ;
    endcase
    a_mag = neg32(rs1_val, a_neg);
    b_mag = neg32(rs2_val, b_neg);
  end

  // Special cases resolved without iterating
  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
`ifdef MULDIV_DIV_EN
    if (op[2] && rs2_val == 32'd0) begin
      fast     = 1'b1;
      fast_res = op[1] ? rs1_val : 32'hFFFF_FFFF;
    end else if (op[2] && !op[0] && rs1_val == 32'h8000_0000 && rs2_val == 32'hFFFF_FFFF) begin
      fast     = 1'b1;
      fast_res = op[1] ? 32'd0 : 32'h8000_0000;
    end
`else
    fast = op[2];
`endif
  end

  // One iteration: hi:lo holds product (multiply) or remainder:quotient (divide)
  always_comb begin
    sum33  = {1'b0, hi_p0} + (lo_p0[0] ? {1'b0, mcand_p0} : 33'd0);
    hi_nxt = sum33[32:1];
    lo_nxt = {sum33[0], lo_p0[31:1]};
`ifdef MULDIV_DIV_EN
    shifted = {hi_p0, lo_p0[31]};
    ge      = (shifted >= {1'b0, mcand_p0});
    sub     = shifted[31:0] - mcand_p0;
    if (op_p0[2]) begin
      hi_nxt = ge ? sub : shifted[31:0];
      lo_nxt = {lo_p0[30:0], ge};
    end
`endif
    prod      = neg64({hi_nxt, lo_nxt}, sign_p0);
    final_res = (op_p0 == 3'b000) ? prod[31:0] : prod[63:32];
`ifdef MULDIV_DIV_EN
    if (op_p0[2]) final_res = neg32(op_p0[1] ? hi_nxt : lo_nxt, sign_p0);
`endif
    last = (cnt_p0 == 6'd31);
  end

  always_comb begin
    state_nxt = state_p0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_p0)
      IDLE: begin
        if (start && !clr) begin
          busy      = 1'b1;
          state_nxt = fast ? DONE : CALC;
        end
      end
      CALC: begin
        busy = ~clr;
        if (clr)       state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operation state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      op_p0    <= '0;
      rd_p0    <= '0;
      sign_p0  <= 1'b0;
      hi_p0    <= '0;
      lo_p0    <= '0;
      mcand_p0 <= '0;
      cnt_p0   <= '0;
      result   <= '0;
      rd_out   <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (state_p0 == IDLE && start && !clr) begin
        op_p0    <= op;
        rd_p0    <= rd;
        sign_p0  <= sign_start;
        cnt_p0   <= '0;
        hi_p0    <= '0;
        lo_p0    <= op[2] ? a_mag : b_mag;
        mcand_p0 <= op[2] ? b_mag : a_mag;
        if (fast) begin
          result <= fast_res;
          rd_out <= rd;
        end
      end else if (state_p0 == CALC && !clr) begin
        hi_p0  <= hi_nxt;
        lo_p0  <= lo_nxt;
        cnt_p0 <= cnt_p0 + 6'd1;
        if (last) begin
          result <= final_res;
          rd_out <= rd_p0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M vectors, fast paths, flush/reset aborts,
// back-to-back issue and randomized ops against an arithmetic reference model.
module tb_ex_muldiv;
  logic        clk = 1'b0;
  logic        rst, clr, start;
  logic [2:0]  op;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd(rd),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
    return o[2] && (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
    return o[2];
`endif
  endfunction

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    logic signed [31:0] as_, bs_, q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    as_ = a;
    bs_ = b;
    case (o)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * zb; return p[63:32]; end
      3'b011: begin p = za * zb; return p[63:32]; end
      default: ;
    endcase
`ifdef MULDIV_DIV_EN
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      3'b100: q = as_ / bs_;
      3'b101: q = a / b;
      3'b110: q = as_ % bs_;
      default: q = a % b;
    endcase
    return q;
`else
    return 32'd0;
`endif
  endfunction

  // Called right after a negedge; returns at the negedge of the done cycle with start still high.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input bit chained);
    logic [31:0] exp;
    int exp_lat, nbusy, dcyc;
    exp = model(o, a, b);
    exp_lat = is_fast(o, a, b) ? 1 : 33;
    op = o; rs1_val = a; rs2_val = b; rd = r; start = 1'b1;
    if (chained) begin
      #1;
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL busy_in_done op=%0d: got %b expected 0", o, busy);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_cycle0 op=%0d: got %b expected 1", o, busy);
    end
    nbusy = (busy === 1'b1) ? 1 : 0;
    dcyc = 0;
    for (int c = 1; c <= 40 && dcyc == 0; c++) begin
      @(negedge clk);
      if (done === 1'b1) dcyc = c;
      else if (busy === 1'b1) nbusy++;
    end
    checks++;
    if (dcyc != exp_lat) begin
      failures++;
      $display("FAIL done_cycle op=%0d a=%h b=%h: got %0d expected %0d (0 = none)", o, a, b, dcyc, exp_lat);
    end
    checks++;
    if (nbusy != exp_lat) begin
      failures++;
      $display("FAIL busy_cycles op=%0d: got %0d expected %0d", o, nbusy, exp_lat);
    end
    checks++;
    if (result !== exp) begin
      failures++;
      $display("FAIL result op=%0d a=%h b=%h: got %h expected %h", o, a, b, result, exp);
    end
    checks++;
    if (rd_out !== r) begin
      failures++;
      $display("FAIL rd_out op=%0d: got %0d expected %0d", o, rd_out, r);
    end
    last_res = exp;
    last_rd = r;
  endtask

  task automatic end_op();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_done: got done=%b busy=%b expected 0 0", done, busy);
    end
    checks++;
    if (result !== last_res) begin
      failures++;
      $display("FAIL result_hold: got %h expected %h", result, last_res);
    end
  endtask

  task automatic watch_no_done(input string name);
    int seen;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL %s_quiet: got %0d active cycles expected 0", name, seen);
    end
    checks++;
    if (result !== last_res || rd_out !== last_rd) begin
      failures++;
      $display("FAIL %s_retain: got %h/%0d expected %h/%0d", name, result, rd_out, last_res, last_rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; start = 1'b0;
    op = '0; rs1_val = '0; rs2_val = '0; rd = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (result !== 32'd0 || rd_out !== 5'd0) begin
      failures++;
      $display("FAIL reset_data: got %h/%0d expected 0/0", result, rd_out);
    end
    rst = 1'b0;
    last_res = '0;
    last_rd = '0;
    @(negedge clk);
  endtask

  task automatic test_multiply();
    run_op(3'b000, 32'd7, 32'd6, 5'd5, 1'b0);                  end_op();
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 1'b0);  end_op();
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0);  end_op();
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b0);  end_op();
    run_op(3'b000, 32'd3, 32'd3, 5'd9, 1'b0);                  end_op();
  endtask

  task automatic test_divide();
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0);  end_op();
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 1'b0);  end_op();
    run_op(3'b101, 32'd100, 32'd7, 5'd12, 1'b0);        end_op();
    run_op(3'b111, 32'd100, 32'd7, 5'd13, 1'b0);        end_op();
    run_op(3'b100, 32'd10, 32'd2, 5'd14, 1'b0);         end_op();
  endtask

  task automatic test_fast_path();
    run_op(3'b101, 32'd5, 32'd0, 5'd15, 1'b0);                   end_op();
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b0);   end_op();
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1'b0);   end_op();
    run_op(3'b111, 32'h1234_5678, 32'd0, 5'd18, 1'b0);           end_op();
  endtask

  task automatic test_back_to_back();
    run_op(3'b000, 32'd3, 32'd3, 5'd1, 1'b0);
    run_op(3'b101, 32'd100, 32'd7, 5'd2, 1'b1);
    run_op(3'b011, $urandom, $urandom, 5'd3, 1'b1);
    end_op();
  endtask

  task automatic test_clr();
    run_op(3'b000, 32'd7, 32'd6, 5'd5, 1'b0);
    end_op();
    op = 3'b011; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h1234_5678; rd = 5'd20; start = 1'b1;
    repeat (10) @(negedge clk);
    clr = 1'b1; start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_busy: got %b expected 0", busy);
    end
    @(negedge clk);
    clr = 1'b0;
    watch_no_done("clr");
  endtask

  task automatic test_clr_start();
    op = 3'b000; rs1_val = 32'd9; rs2_val = 32'd9; rd = 5'd21; start = 1'b1; clr = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_start_busy: got %b expected 0", busy);
    end
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    watch_no_done("clr_start");
  endtask

  task automatic test_rst_mid();
    op = 3'b001; rs1_val = 32'h7FFF_FFFF; rs2_val = 32'h7FFF_FFFF; rd = 5'd22; start = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin
      failures++;
      $display("FAIL rst_mid: got busy=%b done=%b result=%h rd_out=%0d expected all 0",
               busy, done, result, rd_out);
    end
    rst = 1'b0;
    last_res = '0;
    last_rd = '0;
    watch_no_done("rst_mid");
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom; b = 32'd0; end
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: begin a = 32'($urandom_range(0, 300)) - 32'd150; b = 32'($urandom_range(0, 20)) - 32'd10; end
      endcase
      run_op(o, a, b, 5'($urandom_range(0, 31)), 1'b0);
      end_op();
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_fast_path();
    test_back_to_back();
    test_clr();
    test_clr_start();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
